// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM feeder/generator pair: ramp FSM state encoding
// and the default widths both sides must agree on.
package pwm_pkg;

    localparam int PWM_COMPARE_SIZE = 8;
    localparam int PWM_DIV_SIZE     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/pwm_tick_divider.sv
// Count-enable generator for the PWM generator: one-cycle tick every
// tick_div_in+1 sys_clk cycles while enabled.
module pwm_tick_divider
    import pwm_pkg::*;
#(
    parameter int DIV_SIZE = PWM_DIV_SIZE
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [DIV_SIZE-1:0] tick_div_in,
    output logic                tick_out
);

    logic [DIV_SIZE-1:0] div_cnt;

    // >= rather than == so a divisor lowered below the running count still wraps promptly
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_out <= 1'b0;
        end else if (!ena) begin
            tick_out <= 1'b0;
        end else if (div_cnt >= tick_div_in) begin
            div_cnt  <= '0;
            tick_out <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Feeds pwm_generator: produces its count-enable tick and ramps the compare value
// toward a loaded target, presenting every step with a clean wr pulse.
module pwm_ramp_sequencer
    import pwm_pkg::*;
#(
    parameter int COMPARE_SIZE = PWM_COMPARE_SIZE,
    parameter int DIV_SIZE     = PWM_DIV_SIZE,
    parameter int WR_HOLD      = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [DIV_SIZE-1:0]     tick_div_in,
    input  logic [DIV_SIZE-1:0]     rate_in,
    input  logic [COMPARE_SIZE-1:0] step_in,
    input  logic [COMPARE_SIZE-1:0] target_in,
    input  logic                    target_load,
    output logic                    tick_out,
    output logic [COMPARE_SIZE-1:0] compare_out,
    output logic                    wr_out,
    output logic                    busy,
    output logic                    done
);

    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    ramp_state_t             state;
    logic [COMPARE_SIZE-1:0] target;
    logic [COMPARE_SIZE-1:0] step_eff;
    logic [COMPARE_SIZE-1:0] diff;
    logic [COMPARE_SIZE-1:0] next_val;
    logic [DIV_SIZE-1:0]     step_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    tick;
    logic                    load_pending;
    logic                    step_fire;

    assign tick_out = tick;

    pwm_tick_divider #(
        .DIV_SIZE(DIV_SIZE)
    ) u_tick_divider (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .tick_div_in(tick_div_in),
        .tick_out   (tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (target_load) begin
            target <= target_in;
        end
    end

    // The final step is clamped to the target, so the ramp can neither overshoot nor wrap
    always_comb begin
        step_eff = (step_in == '0) ? COMPARE_SIZE'(1) : step_in;
        diff     = (target >= compare_out) ? (target - compare_out) : (compare_out - target);
        next_val = target;
        if (diff > step_eff) begin
            next_val = (target > compare_out) ? (compare_out + step_eff) : (compare_out - step_eff);
        end
    end

    assign load_pending = target_load && (target_in != compare_out);
    assign step_fire    = (state == ST_WAIT) && tick && (step_cnt == rate_in);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            compare_out <= '0;
            wr_out      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    step_cnt <= '0;
                    hold_cnt <= '0;
                    if (target != compare_out) begin
                        state <= ST_WAIT;
                        busy  <= 1'b1;
                    end else begin
                        busy <= load_pending;
                    end
                end
                ST_WAIT: begin
                    if (target == compare_out) begin
                        state    <= ST_IDLE;
                        busy     <= load_pending;
                        step_cnt <= '0;
                    end else if (step_fire) begin
                        compare_out <= next_val;
                        wr_out      <= 1'b1;
                        hold_cnt    <= '0;
                        step_cnt    <= '0;
                        state       <= ST_WRITE;
                    end else if (tick) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                // WRITE and GAP ignore ena so a wr pulse is never truncated
                ST_WRITE: begin
                    if (hold_cnt == HOLD_W'(WR_HOLD - 1)) begin
                        wr_out <= 1'b0;
                        state  <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (target == compare_out) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        busy  <= load_pending;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
